cordic_sin_cos_arbiter: RTL and testbench

Shares one pipelined cordic_sin_cos instance between NUM_REQ independent phase requesters.
- Each CE cycle, a round-robin arbiter accepts at most one request and registers its phase onto the CORDIC input.
- The requester ID travels down a tag pipeline matched to the CORDIC latency.
- SIN/COS results are returned with the ID and a one-hot valid strobe.
- Sits between sensor/NCO consumers and the single cordic_sin_cos datapath.

---
 rtl/cordic_sin_cos_arbiter_if.sv | 30 +++
 rtl/cordic_sin_cos_arbiter.sv | 140 ++++++++++++++
 tb/tb_cordic_sin_cos_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sin_cos_arbiter_if.sv
// cordic_sin_cos_arbiter_if: requester handshake, CORDIC datapath and response signals of the
// shared CORDIC arbiter. The arbiter connects through the slave modport; the requester/CORDIC
// side uses the master modport.
interface cordic_sin_cos_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned PHASE_BITS = 19,
   parameter int unsigned DATA_BITS  = 16,
   parameter int unsigned ID_BITS    = 2
);
   logic [NUM_REQ-1:0]            REQ_VALID;
   logic [NUM_REQ*PHASE_BITS-1:0] REQ_PHASE;
   logic [NUM_REQ-1:0]            REQ_READY;
   logic [PHASE_BITS-1:0]         CORDIC_PHASE;
   logic [DATA_BITS-1:0]          CORDIC_SIN;
   logic [DATA_BITS-1:0]          CORDIC_COS;
   logic [NUM_REQ-1:0]            RESP_VALID;
   logic [ID_BITS-1:0]            RESP_ID;
   logic [DATA_BITS-1:0]          RESP_SIN;
   logic [DATA_BITS-1:0]          RESP_COS;

   modport master (
      output REQ_VALID, REQ_PHASE, CORDIC_SIN, CORDIC_COS,
      input  REQ_READY, CORDIC_PHASE, RESP_VALID, RESP_ID, RESP_SIN, RESP_COS
   );

   modport slave (
      input  REQ_VALID, REQ_PHASE, CORDIC_SIN, CORDIC_COS,
      output REQ_READY, CORDIC_PHASE, RESP_VALID, RESP_ID, RESP_SIN, RESP_COS
   );
endinterface

// File: rtl/cordic_sin_cos_arbiter.sv
// cordic_sin_cos_arbiter: shares one pipelined cordic_sin_cos between NUM_REQ phase requesters.
// A round-robin arbiter accepts at most one request per CE cycle and registers its phase onto
// the CORDIC input; the requester ID follows in a tag pipeline matched to the CORDIC latency and
// comes back with the SIN/COS result and a one-hot valid strobe.
// Optional build macro CORDIC_ARB_FIXED_PRIO0_EN: requester 0 gets strict priority and the
// round-robin pointer only cycles over requesters 1..NUM_REQ-1.
module cordic_sin_cos_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned PHASE_BITS = 19,
   parameter int unsigned DATA_BITS  = 16,
   parameter int unsigned LATENCY    = 12,
   parameter int unsigned ID_BITS    = 2
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     CE,
   cordic_sin_cos_arbiter_if.slave  bus
);

   localparam int unsigned PtrBits = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef CORDIC_ARB_FIXED_PRIO0_EN
   localparam logic [PtrBits-1:0] PtrReset = PtrBits'(1);
`else
   localparam logic [PtrBits-1:0] PtrReset = '0;
`endif

   logic [PtrBits-1:0]          ptr_q, ptr_d;
   logic [PtrBits-1:0]          grant_idx, cand;
   logic                        grant_found;
   logic                        handshake;
   logic [PHASE_BITS-1:0]       grant_phase;
   logic [PHASE_BITS-1:0]       phase_q;
   logic [LATENCY:0]            tag_valid_q;
   logic [LATENCY:0][ID_BITS-1:0] tag_id_q;
   logic [NUM_REQ-1:0]          resp_valid_q;
   logic [ID_BITS-1:0]          resp_id_q;
   logic [DATA_BITS-1:0]        resp_sin_q;
   logic [DATA_BITS-1:0]        resp_cos_q;

   // Grant search: first pending requester at or after the pointer, wrapping around
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
`ifdef CORDIC_ARB_FIXED_PRIO0_EN
      if (bus.REQ_VALID[0]) begin
         grant_found = 1'b1;
      end else begin
         // Pointer lives in 1..NUM_REQ-1, so the search ring excludes requester 0
         for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
            cand = PtrBits'(1 + (32'(ptr_q) - 1 + k) % (NUM_REQ - 1));
            if (!grant_found && bus.REQ_VALID[cand]) begin
               grant_found = 1'b1;
               grant_idx   = cand;
            end
         end
      end
`else
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = PtrBits'((32'(ptr_q) + k) % NUM_REQ);
         if (!grant_found && bus.REQ_VALID[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
`endif
   end

   assign handshake     = grant_found & CE & ~RESET;
   assign bus.REQ_READY = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

   // Phase mux and next pointer for the granted requester
   always_comb begin
      grant_phase = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == PtrBits'(k)) begin
            grant_phase = bus.REQ_PHASE[k*PHASE_BITS +: PHASE_BITS];
         end
      end
      ptr_d = ptr_q;
      if (handshake) begin
`ifdef CORDIC_ARB_FIXED_PRIO0_EN
         // A priority grant to requester 0 leaves the ring position untouched
         if (grant_idx != '0) begin
            ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? PtrBits'(1) : grant_idx + 1'b1;
         end
`else
         ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
      end
   end

   // Round-robin pointer and CORDIC phase register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr_q   <= PtrReset;
         phase_q <= '0;
      end else if (handshake) begin
         ptr_q   <= ptr_d;
         phase_q <= grant_phase;
      end
   end

   // Tag pipeline: stage 0 sits beside phase_q, stage LATENCY beside the CORDIC output
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tag_valid_q <= '0;
         tag_id_q    <= '0;
      end else if (CE) begin
         tag_valid_q <= {tag_valid_q[LATENCY-1:0], handshake};
         tag_id_q    <= {tag_id_q[LATENCY-1:0], ID_BITS'(grant_idx)};
      end
   end

   // Response register: strobe every CE cycle, data only when a result arrives
   always_ff @(posedge CLK) begin
      if (RESET) begin
         resp_valid_q <= '0;
         resp_id_q    <= '0;
         resp_sin_q   <= '0;
         resp_cos_q   <= '0;
      end else if (CE) begin
         if (tag_valid_q[LATENCY]) begin
            resp_valid_q <= NUM_REQ'(1) << tag_id_q[LATENCY];
            resp_id_q    <= tag_id_q[LATENCY];
            resp_sin_q   <= bus.CORDIC_SIN;
            resp_cos_q   <= bus.CORDIC_COS;
         end else begin
            resp_valid_q <= '0;
         end
      end
   end

   assign bus.CORDIC_PHASE = phase_q;
   assign bus.RESP_VALID   = resp_valid_q;
   assign bus.RESP_ID      = resp_id_q;
   assign bus.RESP_SIN     = resp_sin_q;
   assign bus.RESP_COS     = resp_cos_q;

endmodule

// File: tb/tb_cordic_sin_cos_arbiter.sv
// tb_cordic_sin_cos_arbiter: directed bench for cordic_sin_cos_arbiter with a 12-cycle
// behavioural CORDIC stand-in that returns exact octant values for octant-aligned phases.
module tb_cordic_sin_cos_arbiter;

   localparam int NR = 4;
   localparam int PB = 19;
   localparam int LAT = 12;

   // Octant results: index = phase[18:16] for phases with zero low bits
   localparam logic [15:0] EXP_SIN [8] = '{16'h0000, 16'h5A82, 16'h7FFF, 16'h5A82,
                                           16'h0000, 16'hA57E, 16'h8001, 16'hA57E};
   localparam logic [15:0] EXP_COS [8] = '{16'h7FFF, 16'h5A82, 16'h0000, 16'hA57E,
                                           16'h8001, 16'hA57E, 16'h0000, 16'h5A82};

   typedef struct {
      int unsigned cyc;
      logic [3:0]  valid;
      logic [1:0]  id;
      logic [15:0] sin;
      logic [15:0] cos;
   } resp_t;

   logic CLK, RESET, CE;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   resp_t resp_q[$];
   logic mon_ce, mon_rst;

   cordic_sin_cos_arbiter_if #(.NUM_REQ(4), .PHASE_BITS(19), .DATA_BITS(16), .ID_BITS(2)) bus ();

   cordic_sin_cos_arbiter #(
      .NUM_REQ(4), .PHASE_BITS(19), .DATA_BITS(16), .LATENCY(12), .ID_BITS(2)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .CE(CE),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // CORDIC stand-in: exact octant values, otherwise a recognisable pattern of the low bits
   function automatic logic [31:0] cordic_model(input logic [18:0] ph);
      logic [15:0] s, c;
      if (ph[15:0] == 16'h0) begin
         case (ph[18:16])
            3'd0: begin s = 16'h0000; c = 16'h7FFF; end
            3'd1: begin s = 16'h5A82; c = 16'h5A82; end
            3'd2: begin s = 16'h7FFF; c = 16'h0000; end
            3'd3: begin s = 16'h5A82; c = 16'hA57E; end
            3'd4: begin s = 16'h0000; c = 16'h8001; end
            3'd5: begin s = 16'hA57E; c = 16'hA57E; end
            3'd6: begin s = 16'h8001; c = 16'h0000; end
            default: begin s = 16'hA57E; c = 16'h5A82; end
         endcase
      end else begin
         s = ph[15:0];
         c = ~ph[15:0];
      end
      return {s, c};
   endfunction

   logic [18:0] cdl [LAT];
   logic [31:0] stub_out;
   always @(posedge CLK) begin
      if (CE) begin
         cdl[0] <= bus.CORDIC_PHASE;
         for (int i = 1; i < LAT; i++) cdl[i] <= cdl[i-1];
      end
   end
   assign stub_out       = cordic_model(cdl[LAT-1]);
   assign bus.CORDIC_SIN = stub_out[31:16];
   assign bus.CORDIC_COS = stub_out[15:0];

   // Response monitor: logs each result on the CE edge that loaded it
   always @(posedge CLK) begin
      cyc     = cyc + 1;
      mon_ce  = CE;
      mon_rst = RESET;
      @(negedge CLK);
      if (mon_ce && !mon_rst && bus.RESP_VALID != '0)
         resp_q.push_back('{cyc: cyc, valid: bus.RESP_VALID, id: bus.RESP_ID,
                            sin: bus.RESP_SIN, cos: bus.RESP_COS});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_phase(input int i, input logic [18:0] ph);
      bus.REQ_PHASE[i*PB +: PB] = ph;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      CE    = 1'b1;
      bus.REQ_VALID = '0;
      step();
      step();
      RESET = 1'b0;
   endtask

   // Steps until RESP_VALID rises; counts CE=1 edges, -1 when the budget expires
   task automatic wait_resp(input bit toggle_ce, output int ce_edges);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         if (toggle_ce) begin
            CE = 1'b0;
            step();
            CE = 1'b1;
         end
         step();
         n++;
         got = (bus.RESP_VALID != '0);
      end
      ce_edges = got ? n : -1;
      CE = 1'b1;
   endtask

   function automatic int exp_grant(input int g);
`ifdef CORDIC_ARB_FIXED_PRIO0_EN
      return 0;
`else
      return g % 4;
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          lat;
      int unsigned hs0;
      int unsigned hs [4];
      int          nres;
      logic [18:0] p5 [4];
      logic [15:0] s5 [4];
      logic [15:0] c5 [4];

      bus.REQ_PHASE = '0;
      bus.REQ_VALID = '0;
      RESET = 1'b1;
      CE    = 1'b1;

      // Reset state, with requests pending while RESET is high
      bus.REQ_VALID = '1;
      step();
      step();
      check_eq("rst_ready", bus.REQ_READY, 0);
      check_eq("rst_phase", bus.CORDIC_PHASE, 0);
      check_eq("rst_valid", bus.RESP_VALID, 0);
      check_eq("rst_id", bus.RESP_ID, 0);
      check_eq("rst_sin", bus.RESP_SIN, 0);
      check_eq("rst_cos", bus.RESP_COS, 0);
      RESET = 1'b0;
      bus.REQ_VALID = '0;

      // 1: single request, phase 0
      set_phase(0, 19'h00000);
      bus.REQ_VALID = 4'b0001;
      #1;
      check_eq("t1_ready", bus.REQ_READY, 4'b0001);
      step();
      bus.REQ_VALID = '0;
      wait_resp(1'b0, lat);
      check_eq("t1_latency", lat, 13);
      check_eq("t1_valid", bus.RESP_VALID, 4'b0001);
      check_eq("t1_id", bus.RESP_ID, 0);
      check_eq("t1_sin", bus.RESP_SIN, 16'h0000);
      check_eq("t1_cos", bus.RESP_COS, 16'h7FFF);
      step();
      check_eq("t1_valid_drop", bus.RESP_VALID, 0);

      // 2: all four requesters continuously valid
      do_reset();
      resp_q.delete();
      for (int i = 0; i < 4; i++) set_phase(i, 19'(32'h10000 * (i + 1)));
      bus.REQ_VALID = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         #1;
         check_eq($sformatf("t2_grant%0d", g), bus.REQ_READY, 32'(1) << exp_grant(g));
         step();
         if (g == 0) begin
            hs0 = cyc;
            check_eq("t2_phase0", bus.CORDIC_PHASE, 19'h10000);
         end
      end
      bus.REQ_VALID = '0;
      repeat (20) step();
      check_eq("t2_count", resp_q.size(), 8);
      for (int j = 0; j < 8 && j < resp_q.size(); j++) begin
         check_eq($sformatf("t2_cyc%0d", j), resp_q[j].cyc, hs0 + 13 + j);
         check_eq($sformatf("t2_id%0d", j), resp_q[j].id, exp_grant(j));
         check_eq($sformatf("t2_onehot%0d", j), resp_q[j].valid, 32'(1) << exp_grant(j));
         check_eq($sformatf("t2_sin%0d", j), resp_q[j].sin, EXP_SIN[exp_grant(j) + 1]);
         check_eq($sformatf("t2_cos%0d", j), resp_q[j].cos, EXP_COS[exp_grant(j) + 1]);
      end

      // 3: CE toggling during traffic
      resp_q.delete();
      set_phase(1, 19'h20000);
      bus.REQ_VALID = 4'b0010;
      CE = 1'b0;
      #1;
      check_eq("t3_ready_ce0", bus.REQ_READY, 0);
      step();
      check_eq("t3_phase_hold", bus.CORDIC_PHASE, 19'h40000);
      CE = 1'b1;
      #1;
      check_eq("t3_ready_ce1", bus.REQ_READY, 4'b0010);
      step();
      bus.REQ_VALID = '0;
      check_eq("t3_phase", bus.CORDIC_PHASE, 19'h20000);
      wait_resp(1'b1, lat);
      check_eq("t3_ce_latency", lat, 13);
      check_eq("t3_id", bus.RESP_ID, 1);
      check_eq("t3_sin", bus.RESP_SIN, 16'h7FFF);
      check_eq("t3_cos", bus.RESP_COS, 16'h0000);
      CE = 1'b0;
      step();
      check_eq("t3_valid_hold", bus.RESP_VALID, 4'b0010);
      CE = 1'b1;
      step();
      check_eq("t3_valid_clear", bus.RESP_VALID, 0);
      repeat (20) step();
      check_eq("t3_count", resp_q.size(), 1);

      // 4: reset with five results in flight
      do_reset();
      resp_q.delete();
      bus.REQ_VALID = 4'b1111;
      repeat (5) step();
      bus.REQ_VALID = '0;
      repeat (3) step();
      RESET = 1'b1;
      bus.REQ_VALID = 4'b1111;
      #1;
      check_eq("t4_ready_rst", bus.REQ_READY, 0);
      step();
      RESET = 1'b0;
      check_eq("t4_valid", bus.RESP_VALID, 0);
      check_eq("t4_phase", bus.CORDIC_PHASE, 0);
      bus.REQ_VALID = 4'b1100;
      #1;
      check_eq("t4_next_grant", bus.REQ_READY, 4'b0100);
      bus.REQ_VALID = '0;
      repeat (25) step();
      check_eq("t4_no_stale", resp_q.size(), 0);

      // 5: sparse traffic from requester 2, one request every third cycle
      resp_q.delete();
      p5 = '{19'h30000, 19'h50000, 19'h12345, 19'h60000};
      s5 = '{16'h5A82, 16'hA57E, 16'h2345, 16'h8001};
      c5 = '{16'hA57E, 16'hA57E, 16'hDCBA, 16'h0000};
      for (int k = 0; k < 4; k++) begin
         set_phase(2, p5[k]);
         bus.REQ_VALID = 4'b0100;
         #1;
         check_eq($sformatf("t5_ready%0d", k), bus.REQ_READY, 4'b0100);
         step();
         hs[k] = cyc;
         bus.REQ_VALID = '0;
         step();
         step();
      end
      nres = 0;
      for (int n = 0; n < 30; n++) begin
         step();
         if (bus.RESP_VALID != '0) begin
            if (nres < 4) begin
               check_eq($sformatf("t5_valid%0d", nres), bus.RESP_VALID, 4'b0100);
               check_eq($sformatf("t5_sin%0d", nres), bus.RESP_SIN, s5[nres]);
               check_eq($sformatf("t5_cos%0d", nres), bus.RESP_COS, c5[nres]);
            end
            nres++;
         end else if (nres > 0 && nres <= 4) begin
            check_eq("t5_sin_hold", bus.RESP_SIN, s5[nres-1]);
            check_eq("t5_cos_hold", bus.RESP_COS, c5[nres-1]);
         end
      end
      check_eq("t5_count", nres, 4);
      for (int k = 0; k < 4 && k < resp_q.size(); k++) begin
         check_eq($sformatf("t5_cyc%0d", k), resp_q[k].cyc, hs[k] + 13);
         check_eq($sformatf("t5_id%0d", k), resp_q[k].id, 2);
      end

      // 6: requesters 0 and 1 continuously valid
      do_reset();
      bus.REQ_VALID = 4'b0011;
      for (int g = 0; g < 6; g++) begin
         #1;
`ifdef CORDIC_ARB_FIXED_PRIO0_EN
         check_eq($sformatf("t6_prio%0d", g), bus.REQ_READY, 4'b0001);
`else
         check_eq($sformatf("t6_rr%0d", g), bus.REQ_READY, (g % 2 == 0) ? 4'b0001 : 4'b0010);
`endif
         step();
      end
      bus.REQ_VALID = 4'b0010;
      #1;
      check_eq("t6_req1", bus.REQ_READY, 4'b0010);
      step();
      bus.REQ_VALID = '0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
